// File: rtl/sa_pkg.sv
// Types and constants shared between the window generator and the systolic array.
// Holds the default pixel width, the window size and the generator state encoding.
package sa_pkg;
  localparam int PIX_W_DEF = 8;
  localparam int WIN_N     = 9;

  typedef logic [WIN_N-1:0][PIX_W_DEF-1:0] win_t;

  typedef enum logic {S_FILL, S_RUN} state_t;
endpackage

// File: rtl/line_buf.sv
// One image row of storage: registered write, combinational read.
// A read and a write at the same address in one cycle return the old contents.
module line_buf #(
  parameter int DEPTH = 50,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wrEn,
  input  logic [AW-1:0]    i_wrAddr,
  input  logic [WIDTH-1:0] i_wrData,
  input  logic [AW-1:0]    i_rdAddr,
  output logic [WIDTH-1:0] o_rdData
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wrEn) r_mem[i_wrAddr] <= i_wrData;
  end

  assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/window_3x3_gen.sv
// Builds 3x3 scan windows from a raster pixel stream using two line buffers.
// Optional macro WIN_COORD_EN adds win_x/win_y top-left coordinates to each window.
module window_3x3_gen
  import sa_pkg::*;
#(
  parameter int IMG_W = 50,
  parameter int IMG_H = 50,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIX_W-1:0]   in_pix,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [9*PIX_W-1:0] win_data,
  output logic               frame_done
`ifdef WIN_COORD_EN
  ,
  output logic [9:0]         win_x,
  output logic [9:0]         win_y
`endif
);

  localparam int CW    = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H);
  localparam int LB_AW = $clog2(IMG_W);

  logic [CW-1:0] r_col, r_row;
  state_t r_state, w_stateNext;
  logic [WIN_N-1:0][PIX_W-1:0] r_win, w_winNext, r_winData;
  logic r_outValid, r_frameDone;
  logic w_accept, w_colLast, w_rowLast, w_runState, w_emit;
  logic [PIX_W-1:0] w_lb0Rd, w_lb1Rd;

  assign in_ready   = !r_outValid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_colLast  = (r_col == CW'(IMG_W - 1));
  assign w_rowLast  = (r_row == CW'(IMG_H - 1));
  assign out_valid  = r_outValid;
  assign win_data   = r_winData;
  assign frame_done = r_frameDone;

  // lb0 holds the previous row, lb1 the row before it; lb1 is fed from lb0's old value.
  line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk      (clk),
    .i_wrEn   (w_accept),
    .i_wrAddr (r_col[LB_AW-1:0]),
    .i_wrData (in_pix),
    .i_rdAddr (r_col[LB_AW-1:0]),
    .o_rdData (w_lb0Rd)
  );

  line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk      (clk),
    .i_wrEn   (w_accept),
    .i_wrAddr (r_col[LB_AW-1:0]),
    .i_wrData (w_lb0Rd),
    .i_rdAddr (r_col[LB_AW-1:0]),
    .o_rdData (w_lb1Rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FILL;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    if (w_accept && w_colLast) begin
      if (w_rowLast)                w_stateNext = S_FILL;
      else if (r_row == CW'(1))     w_stateNext = S_RUN;
    end
  end

  // Columns 0 and 1 of a row only refill the window, so they never emit.
  always_comb begin
    w_runState = (r_state == S_RUN);
    w_emit     = w_accept && w_runState && (r_col >= CW'(2));
  end

  always_comb begin
    w_winNext = r_win;
    for (int r = 0; r < 3; r++) begin
      w_winNext[3*r]   = r_win[3*r+1];
      w_winNext[3*r+1] = r_win[3*r+2];
    end
    w_winNext[2] = w_lb1Rd;
    w_winNext[5] = w_lb0Rd;
    w_winNext[8] = in_pix;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
      r_win <= '0;
    end else if (w_accept) begin
      r_win <= w_winNext;
      if (w_colLast) begin
        r_col <= '0;
        r_row <= w_rowLast ? '0 : r_row + CW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // A new window replaces the presented one even when it is consumed in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outValid  <= 1'b0;
      r_winData   <= '0;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= w_accept && w_colLast && w_rowLast;
      if (w_emit) begin
        r_outValid <= 1'b1;
        r_winData  <= w_winNext;
      end else if (out_ready) begin
        r_outValid <= 1'b0;
      end
    end
  end

`ifdef WIN_COORD_EN
  logic [9:0] r_winX, r_winY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_winX <= '0;
      r_winY <= '0;
    end else if (w_emit) begin
      r_winX <= 10'(r_col) - 10'd2;
      r_winY <= 10'(r_row) - 10'd2;
    end
  end

  assign win_x = r_winX;
  assign win_y = r_winY;
`endif

endmodule
